criterio_geral: RTL and testbench

CRITERIO_GERAL -- requirements
Module: criterio_geral

---
 rtl/criterio_geral_if.sv | 47 ++++
 rtl/criterio_geral.sv | 164 ++++++++++++++++
 tb/tb_criterio_geral.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/criterio_geral_if.sv
// criterio_geral_if: scan request, per-slot snapshot inputs and
// general-criterion result bundle between the node array and the scanner.
interface criterio_geral_if #(
  parameter int NUM_NA         = 8,
  parameter int ADR_WIDTH      = 5,
  parameter int CRITERIO_WIDTH = 5
);
  localparam int IDX_WIDTH = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

  logic                             iniciar_in;
  logic [NUM_NA-1:0]                na_ativo_in;
  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in;
  logic [NUM_NA*ADR_WIDTH-1:0]      na_endereco_in;

  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_out;
  logic [ADR_WIDTH-1:0]             ca_endereco_out;
  logic [IDX_WIDTH-1:0]             ca_indice_out;
  logic                             ca_valido_out;
  logic                             ca_ocupado_out;
  logic                             ca_pronto_out;

  modport master (
    output iniciar_in,
    output na_ativo_in,
    output na_criterio_in,
    output na_endereco_in,
    input  ca_criterio_geral_out,
    input  ca_endereco_out,
    input  ca_indice_out,
    input  ca_valido_out,
    input  ca_ocupado_out,
    input  ca_pronto_out
  );

  modport slave (
    input  iniciar_in,
    input  na_ativo_in,
    input  na_criterio_in,
    input  na_endereco_in,
    output ca_criterio_geral_out,
    output ca_endereco_out,
    output ca_indice_out,
    output ca_valido_out,
    output ca_ocupado_out,
    output ca_pronto_out
  );
endinterface

// File: rtl/criterio_geral.sv
// criterio_geral: snapshots the active-node table, then scans one slot
// per cycle to find the minimum criterion (lowest index wins ties).
module criterio_geral #(
  parameter int NUM_NA         = 8,
  parameter int ADR_WIDTH      = 5,
  parameter int CRITERIO_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  criterio_geral_if.slave bus
);
  localparam int IDX_WIDTH = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int CW = CRITERIO_WIDTH;
  localparam int AW = ADR_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NA - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic   start, scan, last;

  logic [NUM_NA-1:0]    ativo_q, ativo_d;
  logic [NUM_NA*CW-1:0] crit_q, crit_d;
  logic [NUM_NA*AW-1:0] adr_q, adr_d;

  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]        min_q, min_d;
  logic [IDX_WIDTH-1:0] win_idx_q, win_idx_d;
  logic [AW-1:0]        win_adr_q, win_adr_d;
  logic                 found_q, found_d;

  logic                 cur_act;
  logic [CW-1:0]        cur_crit;
  logic [AW-1:0]        cur_adr;
  logic                 take;

  logic [CW-1:0]        out_crit_q;
  logic [AW-1:0]        out_adr_q;
  logic [IDX_WIDTH-1:0] out_idx_q;
  logic                 out_val_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state control strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    scan    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.iniciar_in) begin
          start   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        scan = 1'b1;
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot capture and running-minimum update for the current slot.
  always_comb begin
    ativo_d   = ativo_q;
    crit_d    = crit_q;
    adr_d     = adr_q;
    idx_d     = idx_q;
    min_d     = min_q;
    win_idx_d = win_idx_q;
    win_adr_d = win_adr_q;
    found_d   = found_q;
    cur_act   = 1'b0;
    cur_crit  = '0;
    cur_adr   = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        cur_act  = ativo_q[i];
        cur_crit = crit_q[i*CW +: CW];
        cur_adr  = adr_q[i*AW +: AW];
      end
    end
    // Strict less-than keeps the earlier slot on a tie.
    take = scan && cur_act && (!found_q || (cur_crit < min_q));
    if (start) begin
      ativo_d   = bus.na_ativo_in;
      crit_d    = bus.na_criterio_in;
      adr_d     = bus.na_endereco_in;
      idx_d     = '0;
      min_d     = '1;
      win_idx_d = '0;
      win_adr_d = '0;
      found_d   = 1'b0;
    end else if (scan) begin
      if (take) begin
        min_d     = cur_crit;
        win_idx_d = idx_q;
        win_adr_d = cur_adr;
        found_d   = 1'b1;
      end
      if (!last) idx_d = idx_q + 1'b1;
    end
  end

  // Snapshot and running registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ativo_q   <= '0;
      crit_q    <= '0;
      adr_q     <= '0;
      idx_q     <= '0;
      min_q     <= '0;
      win_idx_q <= '0;
      win_adr_q <= '0;
      found_q   <= 1'b0;
    end else begin
      ativo_q   <= ativo_d;
      crit_q    <= crit_d;
      adr_q     <= adr_d;
      idx_q     <= idx_d;
      min_q     <= min_d;
      win_idx_q <= win_idx_d;
      win_adr_q <= win_adr_d;
      found_q   <= found_d;
    end
  end

  // Result registers load on entry to DONE so they are valid with pronto.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_crit_q <= '1;
      out_adr_q  <= '0;
      out_idx_q  <= '0;
      out_val_q  <= 1'b0;
    end else if (last) begin
      out_crit_q <= min_d;
      out_adr_q  <= win_adr_d;
      out_idx_q  <= win_idx_d;
      out_val_q  <= found_d;
    end
  end

  assign bus.ca_criterio_geral_out = out_crit_q;
  assign bus.ca_endereco_out       = out_adr_q;
  assign bus.ca_indice_out         = out_idx_q;
  assign bus.ca_valido_out         = out_val_q;
  assign bus.ca_ocupado_out        = (state_q != IDLE);
  assign bus.ca_pronto_out         = (state_q == DONE);

endmodule

// File: tb/tb_criterio_geral.sv
// tb_criterio_geral: table vectors, corner sequences and random scans
// checked against a min-search reference model.
module tb_criterio_geral;
  localparam int NA = 8;
  localparam int AW = 5;
  localparam int CW = 5;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  criterio_geral_if #(
    .NUM_NA(NA), .ADR_WIDTH(AW), .CRITERIO_WIDTH(CW)
  ) bus ();

  criterio_geral #(
    .NUM_NA(NA), .ADR_WIDTH(AW), .CRITERIO_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NA-1:0]    act;
    logic [NA*CW-1:0] crit;
    logic [NA*AW-1:0] adr;
  } stim_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [IW-1:0] i;
    logic [AW-1:0] a;
    logic          v;
  } res_t;

  typedef struct {
    string nm;
    stim_t s;
    res_t  e;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: find the minimum among active slots, then the first
  // slot holding it.
  function automatic res_t model(input stim_t s);
    res_t r;
    int   minv = 1 << CW;
    int   best = -1;
    for (int i = 0; i < NA; i++)
      if (s.act[i] && int'(s.crit[i*CW +: CW]) < minv)
        minv = int'(s.crit[i*CW +: CW]);
    for (int i = 0; i < NA; i++)
      if (best < 0 && s.act[i] && int'(s.crit[i*CW +: CW]) == minv)
        best = i;
    if (best < 0) begin
      r.c = '1; r.i = '0; r.a = '0; r.v = 1'b0;
    end else begin
      r.c = CW'(minv);
      r.i = IW'(best);
      r.a = s.adr[best*AW +: AW];
      r.v = 1'b1;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input stim_t s);
    bus.na_ativo_in    = s.act;
    bus.na_criterio_in = s.crit;
    bus.na_endereco_in = s.adr;
  endtask

  task automatic rand_inputs();
    stim_t s;
    s.act = NA'($urandom);
    for (int i = 0; i < NA; i++) begin
      s.crit[i*CW +: CW] = CW'($urandom);
      s.adr[i*AW +: AW]  = AW'($urandom);
    end
    drive(s);
  endtask

  task automatic check_res(input string nm, input res_t e);
    check({nm, ".crit"}, bus.ca_criterio_geral_out, e.c);
    check({nm, ".idx"}, bus.ca_indice_out, e.i);
    check({nm, ".adr"}, bus.ca_endereco_out, e.a);
    check({nm, ".valid"}, bus.ca_valido_out, e.v);
  endtask

  // Called in an idle cycle; returns in the first idle cycle after DONE.
  task automatic scan_and_check(input string nm, input stim_t s,
                                input res_t e, input bit disturb);
    int lat = 0;
    int busy = 0;
    int extra = 0;
    drive(s);
    bus.iniciar_in = 1'b1;
    step();
    bus.iniciar_in = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.ca_ocupado_out) busy++;
      if (bus.ca_pronto_out) begin
        lat = k;
        break;
      end
      if (disturb) begin
        bus.iniciar_in = (k >= 2);
        rand_inputs();
      end
      step();
    end
    bus.iniciar_in = 1'b0;
    check({nm, ".latency"}, lat, NA + 1);
    check({nm, ".busy"}, busy, NA + 1);
    check_res(nm, e);
    step();
    check({nm, ".pronto_after"}, bus.ca_pronto_out, 0);
    check({nm, ".ocupado_after"}, bus.ca_ocupado_out, 0);
    if (disturb) begin
      for (int k = 0; k < 12; k++) begin
        if (bus.ca_pronto_out || bus.ca_ocupado_out) extra++;
        step();
      end
      check({nm, ".no_queued_scan"}, extra, 0);
      check_res({nm, ".held"}, e);
    end
  endtask

  vec_t  tbl[7];
  stim_t sb;
  res_t  rr;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0].nm = "basic";
    tbl[0].s.act  = 8'b0001_1010;
    tbl[0].s.crit = {5'd0, 5'd0, 5'd0, 5'd15, 5'd10, 5'd0, 5'd20, 5'd0};
    tbl[0].s.adr  = {5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 5'd2, 5'd0};
    tbl[0].e = '{c: 10, i: 3, a: 3, v: 1};
    tbl[1].nm = "tie";
    tbl[1].s.act  = 8'b0010_0100;
    tbl[1].s.crit = {5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0};
    tbl[1].s.adr  = {5'd0, 5'd0, 5'd17, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0};
    tbl[1].e = '{c: 7, i: 2, a: 9, v: 1};
    tbl[2].nm = "empty";
    tbl[2].s.act  = 8'b0000_0000;
    tbl[2].s.crit = {8{5'd3}};
    tbl[2].s.adr  = {8{5'd21}};
    tbl[2].e = '{c: 31, i: 0, a: 0, v: 0};
    tbl[3].nm = "ones_only";
    tbl[3].s.act  = 8'b1000_0000;
    tbl[3].s.crit = {5'd31, 35'd0};
    tbl[3].s.adr  = {5'd13, 35'd0};
    tbl[3].e = '{c: 31, i: 7, a: 13, v: 1};
    tbl[4].nm = "min_last";
    tbl[4].s.act  = 8'hff;
    tbl[4].s.crit = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    tbl[4].s.adr  = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    tbl[4].e = '{c: 1, i: 7, a: 8, v: 1};
    tbl[5].nm = "inactive_smaller";
    tbl[5].s.act  = 8'b0000_0001;
    tbl[5].s.crit = {30'd0, 5'd0, 5'd30};
    tbl[5].s.adr  = {30'd0, 5'd4, 5'd31};
    tbl[5].e = '{c: 30, i: 0, a: 31, v: 1};
    tbl[6].nm = "all_zero";
    tbl[6].s.act  = 8'hff;
    tbl[6].s.crit = '0;
    tbl[6].s.adr  = {8{5'd5}};
    tbl[6].e = '{c: 0, i: 0, a: 5, v: 1};

    // Reset with start asserted: start must be ignored.
    rst = 1'b1;
    bus.iniciar_in = 1'b1;
    drive(tbl[0].s);
    step();
    step();
    check("rst.ocupado", bus.ca_ocupado_out, 0);
    check("rst.pronto", bus.ca_pronto_out, 0);
    check_res("rst", '{c: 31, i: 0, a: 0, v: 0});
    rst = 1'b0;
    bus.iniciar_in = 1'b0;
    step();
    check("rst.idle_after", bus.ca_ocupado_out, 0);

    foreach (tbl[n]) scan_and_check(tbl[n].nm, tbl[n].s, tbl[n].e, 1'b0);

    // Inputs and start toggled during SCAN must not matter.
    scan_and_check("stability", tbl[0].s, tbl[0].e, 1'b1);

    // Reset in the middle of a scan.
    begin
      int pulses = 0;
      drive(tbl[4].s);
      bus.iniciar_in = 1'b1;
      step();
      bus.iniciar_in = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst.ocupado", bus.ca_ocupado_out, 0);
      check("midrst.pronto", bus.ca_pronto_out, 0);
      check_res("midrst", '{c: 31, i: 0, a: 0, v: 0});
      for (int k = 0; k < 12; k++) begin
        if (bus.ca_pronto_out || bus.ca_ocupado_out) pulses++;
        step();
      end
      check("midrst.no_pronto", pulses, 0);
      scan_and_check("after_midrst", tbl[1].s, tbl[1].e, 1'b0);
    end

    // Back-to-back scans with start held high.
    begin
      int first = -1;
      int prev = -1;
      int cnt = 0;
      int drain = 0;
      drive(tbl[3].s);
      bus.iniciar_in = 1'b1;
      step();
      for (int k = 1; k <= 40; k++) begin
        if (bus.ca_pronto_out) begin
          cnt++;
          if (first < 0) first = k;
          else check("b2b.period", k - prev, NA + 2);
          prev = k;
          check_res("b2b", tbl[3].e);
        end
        step();
      end
      bus.iniciar_in = 1'b0;
      check("b2b.first", first, NA + 1);
      check("b2b.count", cnt, 4);
      for (int k = 0; k < 15 && bus.ca_ocupado_out; k++) begin
        drain++;
        step();
      end
      check("b2b.drained", bus.ca_ocupado_out, 0);
    end

    // Random scans against the reference model.
    for (int n = 0; n < 25; n++) begin
      sb.act = NA'($urandom);
      for (int i = 0; i < NA; i++) begin
        if (n % 2 == 0) sb.crit[i*CW +: CW] = CW'($urandom_range(0, 3));
        else            sb.crit[i*CW +: CW] = CW'($urandom);
        sb.adr[i*AW +: AW] = AW'($urandom);
      end
      rr = model(sb);
      scan_and_check($sformatf("rand%0d", n), sb, rr, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
